dsp_mac_ctrl: RTL and testbench

- Sequencer placed directly upstream and downstream of the DSP48A1 slice.
- Accepts a valid/ready stream of signed 18-bit operand pairs and drives the slice's A, B and OPMODE so the slice accumulates N_TAPS products into P.
- Tracks the slice pipeline latency and captures each finished dot product into a 2-entry result buffer with valid/ready output.
- The slice runs with all CE tied high; the controller never stalls the slice, it inserts hold bubbles instead.

---
 rtl/dsp_mac_pkg.sv | 40 ++++
 rtl/dsp_mac_res_fifo.sv | 54 +++++
 rtl/dsp_mac_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dsp_mac_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared constants and types for the DSP48A1 multiply-accumulate sequencer.
package dsp_mac_pkg;

  // OPMODE words driven to the slice (X mux in [1:0], Z mux in [3:2]).
  localparam logic [7:0] OPM_CLR   = 8'h00;  // X=0, Z=0   : P <= 0
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0   : P <= M
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P   : P <= P + M
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P   : P <= P

  // Result FIFO word: {seq[7:0], data[47:0]}.
  localparam int RES_W = 56;

  // What the slice should do with the pair launched in a given cycle.
  typedef enum logic [1:0] {
    TAG_HOLD  = 2'd0,
    TAG_FIRST = 2'd1,
    TAG_ACC   = 2'd2
  } tag_kind_e;

  typedef struct packed {
    tag_kind_e kind;
    logic      last;
  } tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } mac_state_e;

  function automatic logic [7:0] opmode_of(input tag_kind_e kind);
    logic [7:0] opm;
    case (kind)
      TAG_FIRST: opm = OPM_FIRST;
      TAG_ACC:   opm = OPM_ACC;
      default:   opm = OPM_HOLD;
    endcase
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_res_fifo.sv
// Two-entry first-word-fall-through FIFO holding finished dot products
// together with their sequence numbers.
module dsp_mac_res_fifo
  import dsp_mac_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [RES_W-1:0] wdata,
  input  logic             pop,
  output logic [RES_W-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  logic [RES_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Upstream flow control keeps push away from a full FIFO; the guards only
  // make the storage robust against misuse.
  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'd2);

  // Storage, pointers and occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Sequencer wrapped around a DSP48A1 slice: feeds operand pairs into A/B,
// steers OPMODE so the slice accumulates N_TAPS products into P, and captures
// each finished dot product into a small result buffer.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the payload is held stable by
// its source while valid && !ready.
module dsp_mac_ctrl
  import dsp_mac_pkg::*;
#(
  parameter int N_TAPS   = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DLY  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [7:0]  dsp_opmode,
  input  logic [47:0] dsp_p,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [47:0] res_data,
  output logic [7:0]  res_seq,
  output logic        busy,
  output logic        dbg_state
);

  localparam int CNT_W = $clog2(N_TAPS);
  localparam int LIF_W = $clog2(PIPE_LAT + 2);
  localparam int PND_W = LIF_W + 2;

  mac_state_e       state_q;
  mac_state_e       state_d;
  logic [CNT_W-1:0] tap_cnt_q;
  logic [CNT_W-1:0] tap_cnt_d;
  logic             run_q;
  logic             accept;
  logic             at_last;
  logic             hold_last;
  tag_t             tag_now;
  tag_kind_e        tag_pipe [OPM_DLY];
  logic [PIPE_LAT:0] last_pipe;
  logic [LIF_W-1:0] lasts_in_flight;
  logic [PND_W-1:0] pending;
  logic [7:0]       seq_q;
  logic             push;
  logic             pop;
  logic [1:0]       fifo_count;
  logic [RES_W-1:0] fifo_rdata;

  assign at_last = (tap_cnt_q == CNT_W'(N_TAPS - 1));
  assign accept  = in_valid && in_ready;

  // Count LAST flags still travelling towards the capture point.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i <= PIPE_LAT; i++) begin
      lasts_in_flight = lasts_in_flight + LIF_W'(last_pipe[i]);
    end
  end

  // A LAST pair is only taken when its result is guaranteed a FIFO slot,
  // counting results already buffered plus those still in the slice.
  assign pending   = PND_W'(lasts_in_flight) + PND_W'(fifo_count);
  assign hold_last = at_last && (pending >= PND_W'(2));
  assign in_ready  = run_q && !hold_last;

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // FSM state and tap counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      tap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
    end
  end

  // Next state, next tap count and the tag for this cycle's slice launch.
  always_comb begin
    state_d      = state_q;
    tap_cnt_d    = tap_cnt_q;
    tag_now.kind = TAG_HOLD;
    tag_now.last = 1'b0;
    if (accept) begin
      tag_now.kind = (tap_cnt_q == '0) ? TAG_FIRST : TAG_ACC;
      tag_now.last = at_last;
      if (at_last) begin
        tap_cnt_d = '0;
        state_d   = ST_IDLE;
      end else begin
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
        state_d   = ST_ACCUM;
      end
    end
  end

  // Operand registers to the slice; on non-accept cycles they hold and the
  // stale product is masked by a HOLD opmode.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dsp_a <= '0;
      dsp_b <= '0;
    end else if (accept) begin
      dsp_a <= in_a;
      dsp_b <= in_b;
    end
  end

  // Tag pipe: OPMODE lags its pair so it meets the slice's OPMODE register
  // in step with the M register. During reset CLR flushes P.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < OPM_DLY; i++) begin
        tag_pipe[i] <= TAG_HOLD;
      end
      dsp_opmode <= OPM_CLR;
    end else begin
      tag_pipe[0] <= tag_now.kind;
      for (int i = 1; i < OPM_DLY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      dsp_opmode <= opmode_of(tag_pipe[OPM_DLY-1]);
    end
  end

  // LAST flag pipe: when it exits, P holds the finished dot product.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_pipe <= '0;
    end else begin
      last_pipe <= {last_pipe[PIPE_LAT-1:0], tag_now.last};
    end
  end

  assign push = last_pipe[PIPE_LAT];
  assign pop  = res_valid && res_ready;

  // Result sequence number, one step per captured result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seq_q <= 8'd0;
    end else if (push) begin
      seq_q <= seq_q + 8'd1;
    end
  end

  dsp_mac_res_fifo u_res_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .wdata ({seq_q, dsp_p}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (res_valid),
    .count (fifo_count)
  );

  assign res_seq   = fifo_rdata[55:48];
  assign res_data  = fifo_rdata[47:0];
  assign busy      = (state_q == ST_ACCUM) || (lasts_in_flight != '0) || (fifo_count != 2'd0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl paired with a behavioural DSP48A1 slice
// (A1/B1, M, OPMODE and P registers, all CE high).
module tb_dsp_mac_ctrl;

  localparam int N_TAPS     = 4;
  localparam int PIPE_LAT   = 3;
  localparam int OPM_DLY    = 1;
  localparam int WAIT_LIMIT = 200;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] in_a = '0;
  logic [17:0] in_b = '0;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic [7:0]  res_seq;
  logic        busy;
  logic        dbg_state;

  // res_ready mode: 0 = low, 1 = high, 2 = random per cycle
  int   rr_mode = 1;
  logic rr_rand = 1'b0;
  assign res_ready = (rr_mode == 1) || ((rr_mode == 2) && rr_rand);

  always @(posedge CLK) begin
    #1;
    rr_rand <= 1'($urandom_range(0, 1));
  end

  dsp_mac_ctrl #(
    .N_TAPS   (N_TAPS),
    .PIPE_LAT (PIPE_LAT),
    .OPM_DLY  (OPM_DLY)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_seq    (res_seq),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- DSP48A1 slice model ----------------
  logic signed [17:0] a1_reg = '0;
  logic signed [17:0] b1_reg = '0;
  logic signed [35:0] m_reg  = '0;
  logic [7:0]         opm_reg = '0;
  logic [47:0]        p_reg  = '0;
  logic [47:0]        x_mux;
  logic [47:0]        z_mux;

  always_comb begin
    x_mux = '0;
    z_mux = '0;
    if (opm_reg[1:0] == 2'b01) x_mux = {{12{m_reg[35]}}, m_reg};
    if (opm_reg[3:2] == 2'b10) z_mux = p_reg;
  end

  always @(posedge CLK) begin
    a1_reg  <= dsp_a;
    b1_reg  <= dsp_b;
    m_reg   <= a1_reg * b1_reg;
    opm_reg <= dsp_opmode;
    p_reg   <= z_mux + x_mux;
  end
  assign dsp_p = p_reg;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [55:0] exp_q[$];
  longint      acc   = 0;
  int          taps  = 0;
  int          seq_m = 0;

  task automatic model_accept(input logic [17:0] a, input logic [17:0] b);
    logic [47:0] d;
    acc  += longint'($signed(a)) * longint'($signed(b));
    taps++;
    if (taps == N_TAPS) begin
      d = acc[47:0];
      exp_q.push_back({seq_m[7:0], d});
      seq_m = (seq_m + 1) % 256;
      acc   = 0;
      taps  = 0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    acc   = 0;
    taps  = 0;
    seq_m = 0;
  endtask

  // ---------------- scoreboard / output monitor ----------------
  logic        hold_prev = 1'b0;
  logic [55:0] hold_word = '0;
  logic [55:0] exp_word;

  always @(negedge CLK) begin
    if (!RST_N) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check_eq("res_valid_held", res_valid, 1);
        check_eq("res_word_held", {res_seq, res_data}, hold_word);
      end
      if (res_valid && res_ready) begin
        check_eq("exp_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_eq("res_data", res_data, exp_word[47:0]);
          check_eq("res_seq", res_seq, exp_word[55:48]);
        end
      end
      hold_prev <= res_valid && !res_ready;
      hold_word <= {res_seq, res_data};
    end
  end

  // ---------------- driver tasks ----------------
  // All drives happen 1 ns after a rising edge; sampling is on falling edges.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reset_values(input string where);
    check_eq({where, "_in_ready"}, in_ready, 0);
    check_eq({where, "_dsp_a"}, dsp_a, 0);
    check_eq({where, "_dsp_b"}, dsp_b, 0);
    check_eq({where, "_opmode"}, dsp_opmode, 8'h00);
    check_eq({where, "_res_valid"}, res_valid, 0);
    check_eq({where, "_res_data"}, res_data, 0);
    check_eq({where, "_res_seq"}, res_seq, 0);
    check_eq({where, "_busy"}, busy, 0);
    check_eq({where, "_state"}, dbg_state, 0);
  endtask

  task automatic do_reset(input string where);
    in_valid = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_values(where);
    model_clear();
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    check_eq({where, "_ready_before_edge"}, in_ready, 0);
    step();
    check_eq({where, "_ready_after_edge"}, in_ready, 1);
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, output int waits);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waits    = 0;
    @(negedge CLK);
    while (!in_ready && waits < WAIT_LIMIT) begin
      @(negedge CLK);
      waits++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      step();
    end else begin
      step();
      model_accept(a, b);
      check_eq("dsp_a", dsp_a, a);
      check_eq("dsp_b", dsp_b, b);
    end
  endtask

  task automatic wait_idle(input string where);
    int guard;
    guard = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || busy) && guard < WAIT_LIMIT) begin
      step();
      guard++;
    end
    check_eq({where, "_drain_in_time"}, guard < WAIT_LIMIT, 1);
    check_eq({where, "_busy_low"}, busy, 0);
    check_eq({where, "_results_left"}, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  int          w;
  logic [17:0] ra;
  logic [17:0] rb;

  initial begin
    #1;
    do_reset("por");

    // Back-to-back vector
    rr_mode = 1;
    for (int i = 0; i < N_TAPS; i++) begin
      send_pair(18'(2 * i + 1), 18'(2 * i + 2), w);
      check_eq("t1_no_wait", w, 0);
      if (i == 0) check_eq("t1_state_accum", dbg_state, 1);
    end
    wait_idle("t1");
    check_eq("t1_state_idle", dbg_state, 0);

    // Same pairs with two-cycle gaps; HOLD opmode during the gaps
    do_reset("t2");
    for (int i = 0; i < N_TAPS; i++) begin
      send_pair(18'(2 * i + 1), 18'(2 * i + 2), w);
      in_valid = 1'b0;
      step();
      step();
      check_eq("t2_gap_opmode", dsp_opmode, 8'h08);
    end
    wait_idle("t2");

    // Negative products then a second vector with no idle cycle in between
    do_reset("t3");
    for (int i = 0; i < N_TAPS; i++) begin
      send_pair(18'h3FFFF, 18'd1, w);
      check_eq("t3_v0_no_wait", w, 0);
    end
    for (int i = 0; i < N_TAPS; i++) begin
      send_pair(18'd20, 18'd10, w);
      check_eq("t3_v1_no_wait", w, 0);
    end
    wait_idle("t3");

    // Result buffer full: third LAST pair held back until one pop
    do_reset("t4");
    rr_mode = 0;
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N_TAPS; i++) send_pair(18'd1, 18'd1, w);
    end
    for (int i = 0; i < N_TAPS - 1; i++) send_pair(18'd1, 18'd1, w);
    in_valid = 1'b1;
    in_a     = 18'd1;
    in_b     = 18'd1;
    repeat (6) begin
      @(negedge CLK);
      check_eq("t4_last_blocked", in_ready, 0);
      step();
    end
    check_eq("t4_res_valid", res_valid, 1);
    check_eq("t4_head_data", res_data, 48'h4);
    check_eq("t4_head_seq", res_seq, 8'd0);
    rr_mode = 1;
    step();
    rr_mode = 0;
    send_pair(18'd1, 18'd1, w);
    check_eq("t4_last_taken_after_pop", w, 0);
    rr_mode = 1;
    wait_idle("t4");

    // Reset in the middle of a vector
    do_reset("t5");
    send_pair(18'd3, 18'd3, w);
    send_pair(18'd3, 18'd3, w);
    do_reset("t5_mid");
    for (int i = 0; i < N_TAPS; i++) send_pair(18'd2, 18'd2, w);
    wait_idle("t5");

    // Largest magnitude operands
    do_reset("t6");
    for (int i = 0; i < N_TAPS; i++) send_pair(18'h20000, 18'h20000, w);
    wait_idle("t6");

    // Randomized vectors, random gaps and random res_ready
    do_reset("rnd");
    rr_mode = 2;
    for (int v = 0; v < 40; v++) begin
      for (int i = 0; i < N_TAPS; i++) begin
        case ($urandom_range(0, 3))
          0:       ra = 18'h20000;
          1:       ra = 18'h1FFFF;
          default: ra = 18'($urandom);
        endcase
        rb = 18'($urandom);
        send_pair(ra, rb, w);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end
    wait_idle("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
